// File: rtl/aes256_enc_axi_master.sv
// Host-side driver for the AES-256 core's AXI-style slave port: four data beats, a start
// control write, then a watchdog-bounded wait for the ciphertext response.
module aes256_enc_axi_master #(
  parameter logic [31:0] CTRL_START = 32'h0000_0001,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [127:0] block_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [127:0] block_out,
  output logic         dataIn_AXI_valid,
  output logic         addr,
  output logic [31:0]  wdata,
  input  logic         slaveRd,
  output logic         masterRecDataRd,
  input  logic         dataOut_AXI_valid,
  input  logic [127:0] outAES
);

  localparam int unsigned WdW = $clog2(TIMEOUT);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DATA     = 3'd1;
  localparam logic [2:0] CTRL     = 3'd2;
  localparam logic [2:0] WAIT_RES = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [127:0]   blk_q, blk_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
  logic [127:0]   bout_q, bout_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           valid_q, valid_d;
  logic           addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           rec_q, rec_d;
  logic           xfer;

  assign xfer = valid_q & slaveRd;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    wd_d    = wd_q;
    err_d   = err_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          blk_d   = block_in;
          err_d   = 1'b0;
          cnt_d   = 2'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = CTRL;
          end
        end
      end
      CTRL: begin
        if (xfer) begin
          wd_d    = '0;
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        // A response on the watchdog's last cycle still counts as success.
        if (dataOut_AXI_valid) begin
          bout_d  = outAES;
          state_d = DONE;
        end else if (wd_q == WdLast) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they change only on clock edges.
  always_comb begin
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    valid_d = (state_d == DATA) || (state_d == CTRL);
    rec_d   = (state_d == WAIT_RES);
    addr_d  = (state_d != CTRL);
    wdata_d = '0;
    if (state_d == CTRL) begin
      wdata_d = CTRL_START;
    end else if (state_d == DATA) begin
      unique case (cnt_d)
        2'd0: wdata_d = blk_d[127:96];
        2'd1: wdata_d = blk_d[95:64];
        2'd2: wdata_d = blk_d[63:32];
        2'd3: wdata_d = blk_d[31:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      bout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= 1'b1;
      wdata_q <= '0;
      rec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rec_q   <= rec_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign block_out        = bout_q;
  assign dataIn_AXI_valid = valid_q;
  assign addr             = addr_q;
  assign wdata            = wdata_q;
  assign masterRecDataRd  = rec_q;

endmodule
